ahb_matrix_input_hold: RTL and testbench

Master-side input stage of the AHB bus matrix, one instance per master port. It is the requester counterpart of the output-stage arbiter. It forwards the master's address phase to the output stages and raises a request. When its port is not granted, it holds the address phase in a register and stalls the master. It also routes the data-phase ready/response back to the master.

---
 rtl/ahb_matrix_pkg.sv | 51 +++++
 rtl/ahb_matrix_input_hold_if.sv | 50 +++++
 rtl/ahb_matrix_input_hold.sv | 116 +++++++++++
 tb/tb_ahb_matrix_input_hold.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_matrix_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_matrix_pkg : shared AHB encodings and bundle types for the bus matrix |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package ahb_matrix_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase control fields, excluding the address itself
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       mastlock;
  } addr_ctrl_t;

  localparam int ADDR_CTRL_W = $bits(addr_ctrl_t);

  function automatic int addr_phase_w(input int aw);
    return aw + ADDR_CTRL_W;
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE_PASS = 1'b0,
    ST_HELD      = 1'b1
  } hold_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_matrix_input_hold_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_matrix_input_hold_if : master-side and matrix-side signals of one     |
// | input stage. Rev 1.0                                                      |
// +--------------------------------------------------------------------------+
interface ahb_matrix_input_hold_if #(
  parameter int AW = 32
);
  logic          HSELS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES;
  logic [2:0]    HBURSTS;
  logic [3:0]    HPROTS;
  logic          HMASTLOCKS;
  logic          HREADYS;
  logic          HREADYOUTS;
  logic          HRESPS;

  logic          HSELM;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic          HWRITEM;
  logic [2:0]    HSIZEM;
  logic [2:0]    HBURSTM;
  logic [3:0]    HPROTM;
  logic          HMASTLOCKM;
  logic          req_port;
  logic          grant;
  logic          HREADYM;
  logic          HRESPM;

  // The input stage itself
  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, grant, HREADYM, HRESPM,
    output HREADYOUTS, HRESPS, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM,
           HBURSTM, HPROTM, HMASTLOCKM, req_port
  );

  // The surrounding master and matrix fabric
  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, grant, HREADYM, HRESPM,
    input  HREADYOUTS, HRESPS, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM,
           HBURSTM, HPROTM, HMASTLOCKM, req_port
  );
endinterface
`default_nettype wire

// File: rtl/ahb_matrix_input_hold.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_matrix_input_hold : per-master input stage; holds an ungranted        |
// | address phase and stalls the master. Rev 1.0                              |
// +--------------------------------------------------------------------------+
module ahb_matrix_input_hold
  import ahb_matrix_pkg::*;
#(
  parameter int AW      = 32,
  parameter int PORT_ID = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_matrix_input_hold_if.slave bus
);

  localparam int HOLD_W = addr_phase_w(AW);

  hold_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              dphase_q, dphase_d;

  logic          pend, s_valid, m_valid, accept;
  addr_ctrl_t    live_ctrl, held_ctrl;
  logic [AW-1:0] held_addr;
  logic          held_seq;

  logic          sel_m;
  logic [AW-1:0] addr_m;
  logic [1:0]    trans_m;
  logic          write_m;
  logic [2:0]    size_m;
  logic [2:0]    burst_m;
  logic [3:0]    prot_m;
  logic          lock_m;

  always_comb begin
    live_ctrl = {bus.HTRANSS, bus.HWRITES, bus.HSIZES, bus.HBURSTS,
                 bus.HPROTS, bus.HMASTLOCKS};
    {held_addr, held_ctrl} = hold_q;
    pend     = (state_q == ST_HELD);
    s_valid  = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
    accept   = bus.grant & bus.HREADYM;
    held_seq = (held_ctrl.trans == HTRANS_SEQ);

    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE_PASS: begin
        if (s_valid && !accept) begin
          hold_d  = {bus.HADDRS, live_ctrl};
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (accept) state_d = ST_IDLE_PASS;
      end
      default: state_d = ST_IDLE_PASS;
    endcase

    sel_m   = bus.HSELS;
    addr_m  = bus.HADDRS;
    trans_m = bus.HTRANSS;
    write_m = bus.HWRITES;
    size_m  = bus.HSIZES;
    burst_m = bus.HBURSTS;
    prot_m  = bus.HPROTS;
    lock_m  = bus.HMASTLOCKS;
    if (pend) begin
      // Arbitration loss broke the burst, so a held SEQ restarts as NONSEQ/INCR
      sel_m   = 1'b1;
      addr_m  = held_addr;
      trans_m = held_seq ? HTRANS_NONSEQ : held_ctrl.trans;
      write_m = held_ctrl.write;
      size_m  = held_ctrl.size;
      burst_m = held_seq ? HBURST_INCR : held_ctrl.burst;
      prot_m  = held_ctrl.prot;
      lock_m  = held_ctrl.mastlock;
    end

    m_valid  = sel_m & trans_m[1];
    dphase_d = bus.HREADYM ? (bus.grant & m_valid) : dphase_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE_PASS;
      hold_q   <= '0;
      dphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      dphase_q <= dphase_d;
    end
  end

  assign bus.HSELM      = sel_m;
  assign bus.HADDRM     = addr_m;
  assign bus.HTRANSM    = trans_m;
  assign bus.HWRITEM    = write_m;
  assign bus.HSIZEM     = size_m;
  assign bus.HBURSTM    = burst_m;
  assign bus.HPROTM     = prot_m;
  assign bus.HMASTLOCKM = lock_m;

  assign bus.req_port   = pend | (bus.HSELS & bus.HTRANSS[1]);
  assign bus.HREADYOUTS = dphase_q ? bus.HREADYM : ~pend;
  assign bus.HRESPS     = dphase_q ? bus.HRESPM : HRESP_OKAY;

  // A stalled master must not present a new transfer; the hold register keeps the old one
  a_no_new_while_held : assert property (
    @(posedge HCLK) disable iff (!HRESETn) !(pend && s_valid)
  ) else $error("ahb_matrix_input_hold[%0d]: new transfer while held", PORT_ID);

endmodule
`default_nettype wire

// File: tb/tb_ahb_matrix_input_hold.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ahb_matrix_input_hold : directed self-checking bench for the input     |
// | stage. Rev 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ahb_matrix_input_hold;
  import ahb_matrix_pkg::*;

  logic HCLK;
  logic HRESETn;
  int   total;
  int   passed;
  int   failed;

  ahb_matrix_input_hold_if #(.AW(32)) bus ();

  ahb_matrix_input_hold #(.AW(32), .PORT_ID(0)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  // Single-master arrangement: the master bus ready is the stage's own ready
  assign bus.HREADYS = bus.HREADYOUTS;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic master_idle();
    bus.HSELS      = 1'b0;
    bus.HTRANSS    = HTRANS_IDLE;
    bus.HWRITES    = 1'b0;
    bus.HSIZES     = 3'b000;
    bus.HBURSTS    = HBURST_SINGLE;
    bus.HPROTS     = 4'h0;
    bus.HMASTLOCKS = 1'b0;
  endtask

  task automatic master_xfer(input logic [31:0] a, input logic [1:0] t, input logic w,
                             input logic [2:0] sz, input logic [2:0] b, input logic l);
    bus.HSELS      = 1'b1;
    bus.HADDRS     = a;
    bus.HTRANSS    = t;
    bus.HWRITES    = w;
    bus.HSIZES     = sz;
    bus.HBURSTS    = b;
    bus.HPROTS     = 4'h3;
    bus.HMASTLOCKS = l;
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    HRESETn = 1'b0;
    master_idle();
    bus.HADDRS = 32'hDEAD_BEEF;
    bus.grant = 1'b0; bus.HREADYM = 1'b1; bus.HRESPM = 1'b0;
    #3;
    chk("rst_hreadyout", bus.HREADYOUTS, 1);
    chk("rst_hresp", bus.HRESPS, 0);
    chk("rst_req", bus.req_port, 0);
    chk("rst_haddrm_live", bus.HADDRM, 32'hDEAD_BEEF);
    chk("rst_hselm_live", bus.HSELM, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();

    // Granted passthrough
    bus.grant = 1'b1; bus.HREADYM = 1'b1;
    master_xfer(32'h2000_0000, HTRANS_NONSEQ, 1'b0, 3'b010, HBURST_SINGLE, 1'b0);
    #1;
    chk("pass_haddrm", bus.HADDRM, 32'h2000_0000);
    chk("pass_htransm", bus.HTRANSM, 2'b10);
    chk("pass_req", bus.req_port, 1);
    chk("pass_hreadyout", bus.HREADYOUTS, 1);
    tick();
    master_idle(); bus.HREADYM = 1'b0;
    #1;
    chk("pass_dphase_ready0", bus.HREADYOUTS, 0);
    chk("pass_no_pend", bus.req_port, 0);
    bus.HREADYM = 1'b1;
    #1;
    chk("pass_dphase_ready1", bus.HREADYOUTS, 1);
    tick();

    // BUSY is forwarded live, never requested or captured
    bus.grant = 1'b0;
    master_xfer(32'h2000_0010, HTRANS_BUSY, 1'b0, 3'b010, HBURST_INCR, 1'b0);
    #1;
    chk("busy_req", bus.req_port, 0);
    chk("busy_htransm", bus.HTRANSM, 2'b01);
    tick();
    master_idle();
    #1;
    chk("busy_no_capture", bus.HREADYOUTS, 1);

    // Not granted: capture and hold
    master_xfer(32'h1000_0040, HTRANS_NONSEQ, 1'b1, 3'b010, HBURST_INCR, 1'b0);
    #1;
    chk("ng_req", bus.req_port, 1);
    tick();
    master_xfer(32'h3333_0000, HTRANS_NONSEQ, 1'b0, 3'b000, HBURST_SINGLE, 1'b0);
    #1;
    chk("ng_hreadyout", bus.HREADYOUTS, 0);
    chk("ng_haddrm_held", bus.HADDRM, 32'h1000_0040);
    chk("ng_hwritem_held", bus.HWRITEM, 1);
    chk("ng_hsizem_held", bus.HSIZEM, 3'b010);
    chk("ng_hselm", bus.HSELM, 1);
    master_idle(); bus.HADDRS = 32'h3333_0000;
    #1;
    chk("ng_req_pend", bus.req_port, 1);
    tick();
    chk("ng_stall_no_grant", bus.HREADYOUTS, 0);
    chk("ng_haddrm_still", bus.HADDRM, 32'h1000_0040);
    bus.grant = 1'b1; bus.HREADYM = 1'b1;
    tick();
    bus.HREADYM = 1'b0;
    #1;
    chk("ng_released_live", bus.HADDRM, 32'h3333_0000);
    chk("ng_dphase_follows", bus.HREADYOUTS, 0);
    chk("ng_req_clear", bus.req_port, 0);
    bus.HREADYM = 1'b1;
    tick();

    // Held SEQ restarts as NONSEQ/INCR; lock kept from the hold register
    bus.grant = 1'b0;
    master_xfer(32'h4000_0004, HTRANS_SEQ, 1'b0, 3'b010, HBURST_INCR4, 1'b1);
    tick();
    master_idle();
    #1;
    chk("seq_htransm", bus.HTRANSM, 2'b10);
    chk("seq_hburstm", bus.HBURSTM, 3'b001);
    chk("seq_haddrm", bus.HADDRM, 32'h4000_0004);
    chk("seq_lock_held", bus.HMASTLOCKM, 1);
    bus.grant = 1'b1;
    tick();

    // Two-cycle ERROR response
    bus.HRESPM = 1'b1; bus.HREADYM = 1'b0;
    #1;
    chk("err1_hresp", bus.HRESPS, 1);
    chk("err1_hreadyout", bus.HREADYOUTS, 0);
    tick();
    bus.HREADYM = 1'b1;
    bus.HSELS = 1'b1; bus.HTRANSS = HTRANS_IDLE;
    #1;
    chk("err2_hresp", bus.HRESPS, 1);
    chk("err2_hreadyout", bus.HREADYOUTS, 1);
    chk("err2_req", bus.req_port, 0);
    tick();
    chk("err_after_hresp", bus.HRESPS, 0);
    chk("err_after_ready", bus.HREADYOUTS, 1);
    bus.HRESPM = 1'b0;
    master_idle();
    tick();

    // Wait states during a granted data phase
    master_xfer(32'h5000_0000, HTRANS_NONSEQ, 1'b0, 3'b010, HBURST_SINGLE, 1'b0);
    tick();
    master_idle(); bus.HREADYM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_hreadyout", bus.HREADYOUTS, 0);
      chk("wait_no_capture", bus.req_port, 0);
      tick();
    end
    bus.HREADYM = 1'b1;
    #1;
    chk("wait_done", bus.HREADYOUTS, 1);
    tick();

    // Reset while holding
    bus.grant = 1'b0;
    master_xfer(32'h6000_0000, HTRANS_NONSEQ, 1'b1, 3'b010, HBURST_SINGLE, 1'b0);
    tick();
    master_idle(); bus.HADDRS = 32'h7777_0000;
    #1;
    chk("rsth_stalled", bus.HREADYOUTS, 0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rsth_hreadyout", bus.HREADYOUTS, 1);
    chk("rsth_req", bus.req_port, 0);
    chk("rsth_haddrm_live", bus.HADDRM, 32'h7777_0000);
    chk("rsth_hselm", bus.HSELM, 0);
    #1;
    HRESETn = 1'b1;
    tick();
    chk("rsth_after", bus.HREADYOUTS, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
